// File: rtl/step_sequencer_core.sv
// ---------------------------------------------------------------------------
// step_sequencer_core
//
// Playback engine for the piano step sequencer. Holds a NUM_STEPS x
// NUM_VOICES pattern memory and walks through it at a runtime-programmable
// step period. The active length, loop count, pause and stop are all
// programmable. Voices drives the tone select of the audio generator, and
// Play gates the DAC path.
//
// Ports
//   Clock      system clock (50 MHz)
//   nReset     synchronous active-low reset; the pattern memory is kept
//   nStart     active-low start request, acts on its falling edge
//   Stop       abort playback, return to idle without a Done pulse
//   Pause      level; freezes tick, step index and voices while high
//   Period     clocks per step (values below 2 act as 2); latched per step
//   Loops      loops to play, 0 = play until Stop
//   Length     active steps per loop (0 or > NUM_STEPS act as NUM_STEPS)
//   WrEn/WrAddr/WrData  synchronous pattern write port, usable in any state
//   Play       high in PLAY and PAUSE
//   Step       one-cycle pulse at every step boundary, including step 0
//   StepIdx    current step index
//   Voices     tone mask of the current step; 0 when not playing
//   LoopCount  completed loops, saturating
//   Done       one-cycle pulse when the programmed loops are exhausted
// ---------------------------------------------------------------------------
module step_sequencer_core #(
    parameter int NUM_STEPS  = 16,
    parameter int NUM_VOICES = 12,
    parameter int TICK_W     = 32,
    parameter int LOOP_W     = 8,
    parameter int STEP_W     = $clog2(NUM_STEPS),
    parameter int LEN_W      = $clog2(NUM_STEPS + 1)
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  nStart,
    input  logic                  Stop,
    input  logic                  Pause,
    input  logic [TICK_W-1:0]     Period,
    input  logic [LOOP_W-1:0]     Loops,
    input  logic [LEN_W-1:0]      Length,
    input  logic                  WrEn,
    input  logic [STEP_W-1:0]     WrAddr,
    input  logic [NUM_VOICES-1:0] WrData,
    output logic                  Play,
    output logic                  Step,
    output logic [STEP_W-1:0]     StepIdx,
    output logic [NUM_VOICES-1:0] Voices,
    output logic [LOOP_W-1:0]     LoopCount,
    output logic                  Done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Period and length as latched at start / step boundaries.
    typedef struct packed {
        logic [TICK_W-1:0] period;
        logic [LEN_W-1:0]  len;
    } cfg_t;

    // ------------------------------------------------------------------
    // Pattern memory. Not reset. A write and a load of the same address
    // in one cycle return the old word because both happen on the same
    // edge and the load samples the array before the write lands.
    // ------------------------------------------------------------------
    logic [NUM_VOICES-1:0] pattern_mem [NUM_STEPS];

    always_ff @(posedge Clock) begin
        if (WrEn)
            pattern_mem[WrAddr] <= WrData;
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q,  state_n;
    logic [TICK_W-1:0]     tick_q,   tick_n;
    logic [STEP_W-1:0]     idx_q,    idx_n;
    logic [NUM_VOICES-1:0] voices_q, voices_n;
    logic [LOOP_W-1:0]     loop_q,   loop_n;
    logic                  step_q,   step_n;
    logic                  done_q,   done_n;
    cfg_t                  cfg_q,    cfg_n;
    logic                  nstart_q;

    // ------------------------------------------------------------------
    // Input conditioning and per-cycle decisions
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] period_clamped;
    logic [LEN_W-1:0]  len_clamped;
    logic              start_req;
    logic              step_end;
    logic              last_step;
    logic [LOOP_W:0]   loop_inc;
    logic [LOOP_W-1:0] loop_sat;
    logic              loops_done;

    assign period_clamped = (Period < TICK_W'(2)) ? TICK_W'(2) : Period;
    assign len_clamped    = (Length == '0 || Length > LEN_W'(NUM_STEPS))
                          ? LEN_W'(NUM_STEPS) : Length;

    // Falling edge of nStart; a held-low nStart fires only once.
    assign start_req  = nstart_q & ~nStart;

    assign step_end   = (tick_q == cfg_q.period - TICK_W'(1));
    assign last_step  = !(LEN_W'(idx_q) < cfg_q.len - LEN_W'(1));

    // One extra bit so the Loops compare sees the true count even when the
    // visible counter has saturated.
    assign loop_inc   = {1'b0, loop_q} + (LOOP_W + 1)'(1);
    assign loop_sat   = loop_inc[LOOP_W] ? {LOOP_W{1'b1}} : loop_inc[LOOP_W-1:0];
    assign loops_done = (Loops != '0) && (loop_inc >= {1'b0, Loops});

    // ------------------------------------------------------------------
    // Next-state / output logic. Priority: Stop > start > Pause > tick.
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state_q;
        tick_n   = tick_q;
        idx_n    = idx_q;
        voices_n = voices_q;
        loop_n   = loop_q;
        step_n   = 1'b0;
        done_n   = 1'b0;
        cfg_n    = cfg_q;

        if (Stop) begin
            // In IDLE this is a no-op: these registers are already clear.
            state_n  = ST_IDLE;
            tick_n   = '0;
            idx_n    = '0;
            voices_n = '0;
        end else if (start_req) begin
            // Start from any state, including a restart mid-play.
            state_n  = ST_PLAY;
            tick_n   = '0;
            idx_n    = '0;
            voices_n = pattern_mem[0];
            loop_n   = '0;
            step_n   = 1'b1;
            cfg_n    = '{period: period_clamped, len: len_clamped};
        end else if (state_q != ST_IDLE) begin
            if (Pause) begin
                // Frozen: tick, index and voices hold.
                state_n = ST_PAUSE;
            end else begin
                // The cycle Pause drops already counts, so a pause of N
                // cycles delays the next boundary by exactly N cycles.
                state_n = ST_PLAY;
                if (!step_end) begin
                    tick_n = tick_q + TICK_W'(1);
                end else begin
                    tick_n       = '0;
                    // A new Period takes effect from the step that begins here.
                    cfg_n.period = period_clamped;
                    if (!last_step) begin
                        idx_n    = idx_q + STEP_W'(1);
                        voices_n = pattern_mem[idx_q + STEP_W'(1)];
                        step_n   = 1'b1;
                    end else begin
                        loop_n = loop_sat;
                        if (loops_done) begin
                            state_n  = ST_IDLE;
                            idx_n    = '0;
                            voices_n = '0;
                            done_n   = 1'b1;
                        end else begin
                            idx_n     = '0;
                            voices_n  = pattern_mem[0];
                            step_n    = 1'b1;
                            cfg_n.len = len_clamped;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers with synchronous active-low reset
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            idx_q    <= '0;
            voices_q <= '0;
            loop_q   <= '0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
            cfg_q    <= '{period: TICK_W'(2), len: LEN_W'(NUM_STEPS)};
            nstart_q <= 1'b1;
        end else begin
            state_q  <= state_n;
            tick_q   <= tick_n;
            idx_q    <= idx_n;
            voices_q <= voices_n;
            loop_q   <= loop_n;
            step_q   <= step_n;
            done_q   <= done_n;
            cfg_q    <= cfg_n;
            nstart_q <= nStart;
        end
    end

    assign Play      = (state_q != ST_IDLE);
    assign Step      = step_q;
    assign StepIdx   = idx_q;
    assign Voices    = voices_q;
    assign LoopCount = loop_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_step_sequencer_core.sv
// ---------------------------------------------------------------------------
// Bench for step_sequencer_core. Expected outputs for an undisturbed run
// come from a closed-form model: with effective period P, length L and
// loops N, the cycle t after start belongs to step k = t/P, which shows
// pattern[k % L], has completed k / L loops, and Done lands at t = N*L*P.
// Pause, stop, reset, write collisions and period changes are directed.
// ---------------------------------------------------------------------------
module tb_step_sequencer_core;
    localparam int NS   = 16;
    localparam int NV   = 12;
    localparam int TW   = 32;
    localparam int LW   = 8;
    localparam int SW   = 4;
    localparam int LENW = 5;

    logic          Clock  = 1'b0;
    logic          nReset = 1'b0;
    logic          nStart = 1'b1;
    logic          Stop   = 1'b0;
    logic          Pause  = 1'b0;
    logic [TW-1:0] Period = 4;
    logic [LW-1:0] Loops  = 0;
    logic [LENW-1:0] Length = 0;
    logic          WrEn   = 1'b0;
    logic [SW-1:0] WrAddr = '0;
    logic [NV-1:0] WrData = '0;
    logic          Play, Step, Done;
    logic [SW-1:0] StepIdx;
    logic [NV-1:0] Voices;
    logic [LW-1:0] LoopCount;

    int checks = 0;
    int errors = 0;
    logic [NV-1:0] pat [NS];

    step_sequencer_core dut (
        .Clock(Clock), .nReset(nReset), .nStart(nStart), .Stop(Stop),
        .Pause(Pause), .Period(Period), .Loops(Loops), .Length(Length),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .Play(Play), .Step(Step), .StepIdx(StepIdx), .Voices(Voices),
        .LoopCount(LoopCount), .Done(Done)
    );

    always #10 Clock = ~Clock;

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [NV-1:0] d);
        WrEn = 1'b1; WrAddr = SW'(a); WrData = d;
        cyc();
        WrEn = 1'b0;
        pat[a] = d;
    endtask

    task automatic start();
        nStart = 1'b0;
        cyc();
        nStart = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_play"},   Play,    0);
        chk({tag, "_step"},   Step,    0);
        chk({tag, "_voices"}, Voices,  0);
        chk({tag, "_done"},   Done,    0);
    endtask

    function automatic int eff_p(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic int eff_l(input int l);
        return (l == 0 || l > NS) ? NS : l;
    endfunction

    // Called right after start(): checks cycles t = 0.. against the model.
    // n != 0: runs through the Done cycle and one more; n == 0: tmax cycles.
    task automatic run_check(input string tag, input int p, input int l,
                             input int n, input int tmax);
        int lim, k, fin;
        fin = n * l * p;
        lim = (n != 0) ? fin + 2 : tmax;
        for (int t = 0; t < lim; t++) begin
            if (n != 0 && t >= fin) begin
                chk({tag, "_end_play"},   Play,      0);
                chk({tag, "_end_done"},   Done,      (t == fin));
                chk({tag, "_end_voices"}, Voices,    0);
                chk({tag, "_end_step"},   Step,      0);
                chk({tag, "_end_idx"},    StepIdx,   0);
                chk({tag, "_end_loops"},  LoopCount, n);
            end else begin
                k = t / p;
                chk({tag, "_step"},   Step,      (t % p == 0));
                chk({tag, "_idx"},    StepIdx,   k % l);
                chk({tag, "_voices"}, Voices,    pat[k % l]);
                chk({tag, "_loops"},  LoopCount, k / l);
                chk({tag, "_play"},   Play,      1);
                chk({tag, "_done"},   Done,      0);
            end
            if (t + 1 < lim) cyc();
        end
    endtask

    initial begin
        int pr, lr, nr, gap;
        logic found;
        logic [NV-1:0] old_w, new_w;

        // Reset state
        cyc(); cyc();
        nReset = 1'b1;
        chk_idle("reset");
        chk("reset_idx",   StepIdx,   0);
        chk("reset_loops", LoopCount, 0);

        for (int i = 0; i < NS; i++)
            wr(i, (i < 12) ? NV'(12'h001 << i) : NV'($urandom));

        // Basic run: P=4, L=4, two loops
        Period = 4; Length = 4; Loops = 2;
        start();
        run_check("basic", 4, 4, 2, 0);
        cyc();

        // Infinite loops then Stop after 40 steps
        Period = 3; Length = 16; Loops = 0;
        start();
        run_check("inf", 3, 16, 0, 120);
        Stop = 1'b1; cyc(); Stop = 1'b0;
        chk_idle("stop");
        chk("stop_loops", LoopCount, 2);
        cyc();
        chk("stop_done2", Done, 0);

        // Pause mid-step at tick 2 for 7 cycles
        Period = 5; Length = 4; Loops = 0;
        start();
        cyc(); cyc();
        Pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("pause_idx",    StepIdx, 0);
            chk("pause_voices", Voices,  pat[0]);
            chk("pause_step",   Step,    0);
            chk("pause_play",   Play,    1);
        end
        Pause = 1'b0;
        found = 1'b0; gap = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            cyc();
            if (Step) begin found = 1'b1; gap = i; end
        end
        chk("pause_gap", gap, 3);
        chk("pause_next_idx", StepIdx, 1);
        Stop = 1'b1; cyc(); Stop = 1'b0;

        // Clamping of Period and Length
        Period = 0; Length = 0; Loops = 1;
        start();
        run_check("p0_l0", 2, 16, 1, 0);
        Period = 1; Length = 20;
        start();
        run_check("p1_l20", 2, 16, 1, 0);

        // Write to the step being loaded: old data now, new data next loop
        Period = 4; Length = 4; Loops = 0;
        old_w = pat[1]; new_w = ~pat[1];
        start();
        for (int t = 0; t <= 21; t++) begin
            if (t == 3) begin WrEn = 1'b1; WrAddr = 1; WrData = new_w; end
            if (t == 4) begin
                WrEn = 1'b0;
                chk("rbw_old",  Voices,  old_w);
                chk("rbw_step", Step,    1);
                chk("rbw_idx",  StepIdx, 1);
            end
            if (t == 20) begin
                chk("rbw_new",     Voices,  new_w);
                chk("rbw_new_idx", StepIdx, 1);
            end
            cyc();
        end
        pat[1] = new_w;
        Stop = 1'b1; cyc(); Stop = 1'b0;

        // Period change 4 -> 8 mid-step
        Period = 4; Length = 16; Loops = 0;
        start();
        for (int t = 0; t < 14; t++) begin
            if (t == 1) Period = 8;
            chk("per_chg_step", Step, (t == 0 || t == 4 || t == 12));
            cyc();
        end
        Stop = 1'b1; cyc(); Stop = 1'b0;

        // Reset mid-play at step 5; pattern survives
        Period = 2; Length = 16; Loops = 0;
        start();
        for (int i = 0; i < 10; i++) cyc();
        chk("pre_rst_idx", StepIdx, 5);
        nReset = 1'b0; cyc(); nReset = 1'b1;
        chk_idle("midrst");
        chk("midrst_idx",   StepIdx,   0);
        chk("midrst_loops", LoopCount, 0);
        start();
        run_check("post_rst", 2, 16, 0, 34);

        // Stop together with a start edge: while playing, then from idle
        Stop = 1'b1; nStart = 1'b0; cyc(); Stop = 1'b0;
        chk_idle("stopstart_play");
        cyc();
        chk("stopstart_hold", Play, 0);
        nStart = 1'b1; cyc();
        Stop = 1'b1; nStart = 1'b0; cyc(); Stop = 1'b0; nStart = 1'b1;
        chk_idle("stopstart_idle");
        cyc();

        // Randomized runs against the closed-form model
        for (int r = 0; r < 6; r++) begin
            wr(int'($urandom_range(0, NS - 1)), NV'($urandom));
            wr(int'($urandom_range(0, NS - 1)), NV'($urandom));
            pr = int'($urandom_range(0, 6));
            lr = int'($urandom_range(0, 31));
            nr = int'($urandom_range(1, 3));
            Period = TW'(pr); Length = LENW'(lr); Loops = LW'(nr);
            start();
            run_check("rnd", eff_p(pr), eff_l(lr), nr, 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
